// File: rtl/fp_addsub_arbiter.sv
// Round-robin sequencer sharing one combinational FP add/sub unit.
// Operands are registered onto the unit, held while it settles, then returned.
module fp_addsub_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_op,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [31:0]            resp_res,
    output logic                   resp_exception,
    output logic [31:0]            fpu_a,
    output logic [31:0]            fpu_b,
    output logic                   fpu_op,
    input  logic [31:0]            fpu_res,
    input  logic                   fpu_exception,
    output logic                   busy,
    output logic [15:0]            ops_count,
    output logic [15:0]            exc_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_id;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic          found;
    logic [CW-1:0] cnt;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;
    logic          sel_op;

    // Search upward from rr_ptr with wrap; first valid port wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PW'(i)) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[win] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            gnt_id         <= '0;
            cnt            <= '0;
            fpu_a          <= '0;
            fpu_b          <= '0;
            fpu_op         <= 1'b0;
            resp_res       <= '0;
            resp_exception <= 1'b0;
            resp_valid     <= '0;
            ops_count      <= '0;
            exc_count      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        fpu_a  <= sel_a;
                        fpu_b  <= sel_b;
                        fpu_op <= sel_op;
                        gnt_id <= win;
                        cnt    <= CW'(SETTLE_CYCLES);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        resp_res       <= fpu_res;
                        resp_exception <= fpu_exception;
                        resp_valid     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[gnt_id]) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                        rr_ptr     <= (gnt_id == PW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
                        if (ops_count != 16'hFFFF)
                            ops_count <= ops_count + 16'd1;
                        if (resp_exception && exc_count != 16'hFFFF)
                            exc_count <= exc_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter; the shared unit is a lookup model.
module tb_fp_addsub_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_op;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [31:0]  resp_res;
    logic         resp_exception;
    logic [31:0]  fpu_a;
    logic [31:0]  fpu_b;
    logic         fpu_op;
    logic [31:0]  fpu_res;
    logic         fpu_exception;
    logic         busy;
    logic [15:0]  ops_count;
    logic [15:0]  exc_count;

    int checks = 0;
    int errors = 0;
    int ng;
    int gcyc[5];
    logic [3:0] graw[5];
    logic [31:0] held_res;

    fp_addsub_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_res(resp_res), .resp_exception(resp_exception),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_res(fpu_res), .fpu_exception(fpu_exception),
        .busy(busy), .ops_count(ops_count), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    // Known IEEE-754 results; anything else gets a recognisable pattern.
    always_comb begin
        fpu_res       = fpu_a ^ fpu_b;
        fpu_exception = 1'b0;
        case ({fpu_a, fpu_b, fpu_op})
            {32'h420151EC, 32'h4242147B, 1'b0}: fpu_res = 32'h42A1B333;
            {32'h40A00000, 32'h40C00000, 1'b1}: fpu_res = 32'hBF800000;
            {32'h3F800000, 32'h40000000, 1'b0}: fpu_res = 32'h40400000;
            {32'h7F800000, 32'h3EC7AE14, 1'b0}: begin
                fpu_res       = 32'h7F800000;
                fpu_exception = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fpu_a", fpu_a, 32'h0);
        chk("rst_ops", 32'(ops_count), 32'h0);
        chk("rst_res", resp_res, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // single add on port 0
        req_a[31:0] = 32'h420151EC;
        req_b[31:0] = 32'h4242147B;
        req_op      = 4'b0000;
        req_valid   = 4'b0001;
        #1;
        chk("add_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        chk("add_fpu_a", fpu_a, 32'h420151EC);
        chk("add_fpu_b", fpu_b, 32'h4242147B);
        chk("add_fpu_op", 32'(fpu_op), 32'h0);
        chk("add_busy", 32'(busy), 32'h1);
        chk("add_rv_c1", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("add_rv_c2", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("add_rv_c3", 32'(resp_valid), 32'h1);
        chk("add_res", resp_res, 32'h42A1B333);
        chk("add_exc", 32'(resp_exception), 32'h0);
        resp_ready = 4'b1111;
        @(negedge clk);
        chk("add_rv_done", 32'(resp_valid), 32'h0);
        chk("add_ops", 32'(ops_count), 32'h1);
        chk("add_idle", 32'(busy), 32'h0);

        // subtract on port 2
        req_a[95:64] = 32'h40A00000;
        req_b[95:64] = 32'h40C00000;
        req_op       = 4'b0100;
        req_valid    = 4'b0100;
        #1;
        chk("sub_req_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        chk("sub_rv_c1", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("sub_rv_c2", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("sub_rv_c3", 32'(resp_valid), 32'h4);
        chk("sub_res", resp_res, 32'hBF800000);
        @(negedge clk);
        chk("sub_rv_done", 32'(resp_valid), 32'h0);
        chk("sub_ops", 32'(ops_count), 32'h2);

        // exception on port 3
        req_a[127:96] = 32'h7F800000;
        req_b[127:96] = 32'h3EC7AE14;
        req_op        = 4'b0000;
        req_valid     = 4'b1000;
        #1;
        chk("exc_req_ready", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("exc_rv", 32'(resp_valid), 32'h8);
        chk("exc_res", resp_res, 32'h7F800000);
        chk("exc_flag", 32'(resp_exception), 32'h1);
        @(negedge clk);
        chk("exc_ops", 32'(ops_count), 32'h3);
        chk("exc_count", 32'(exc_count), 32'h1);

        // backpressure on port 1; port 0 requests and ready are ignored
        resp_ready   = 4'b0001;
        req_a[63:32] = 32'h3F800000;
        req_b[63:32] = 32'h40000000;
        req_valid    = 4'b0010;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("bp_rv", 32'(resp_valid), 32'h2);
        chk("bp_res", resp_res, 32'h40400000);
        held_res  = resp_res;
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_hold_rv", 32'(resp_valid), 32'h2);
            chk("bp_hold_res", resp_res, held_res);
            chk("bp_hold_rdy", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        req_valid  = '0;
        resp_ready = 4'b0010;
        @(negedge clk);
        chk("bp_rv_done", 32'(resp_valid), 32'h0);
        chk("bp_ops", 32'(ops_count), 32'h4);
        chk("bp_idle", 32'(busy), 32'h0);

        // fairness from reset with all ports requesting
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_ops", 32'(ops_count), 32'h0);
        chk("rst2_exc", 32'(exc_count), 32'h0);
        chk("rst2_res", resp_res, 32'h0);
        resp_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h3F000000 + 32'(i);
            req_b[32*i +: 32] = 32'h00000100;
        end
        req_op    = '0;
        reset     = 1'b1;
        req_valid = 4'b1111;
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            if (req_ready != 4'b0000) begin
                graw[ng] = req_ready;
                gcyc[ng] = c;
                ng++;
                if (ng == 5)
                    req_valid = '0;
            end
            if (ng < 5)
                @(negedge clk);
        end
        chk("rr_grant_count", 32'(ng), 32'd5);
        for (int k = 0; k < ng; k++) begin
            chk("rr_order", 32'(graw[k]), 32'(4'b0001 << (k % 4)));
            if (k > 0)
                chk("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd4);
        end
        @(negedge clk);
        chk("rr_ops", 32'(ops_count), 32'h4);

        // one op on port 1 moves the pointer to 2, then reset mid-EXEC
        req_valid = 4'b0010;
        #1;
        chk("pre_req_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("pre_ops", 32'(ops_count), 32'h5);
        req_a[127:96] = 32'h40A00000;
        req_b[127:96] = 32'h40C00000;
        req_valid     = 4'b1000;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = '0;
        chk("abort_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_fpu_a", fpu_a, 32'h0);
        chk("abort_fpu_b", fpu_b, 32'h0);
        chk("abort_fpu_op", 32'(fpu_op), 32'h0);
        chk("abort_res", resp_res, 32'h0);
        chk("abort_exc", 32'(resp_exception), 32'h0);
        chk("abort_rv", 32'(resp_valid), 32'h0);
        chk("abort_busy0", 32'(busy), 32'h0);
        chk("abort_ops", 32'(ops_count), 32'h0);
        chk("abort_excc", 32'(exc_count), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rv", 32'(resp_valid), 32'h0);
        end
        req_valid = 4'b1111;
        #1;
        chk("abort_first_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational single-precision add/sub unit (ADD_SUB_2021) among NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake and registers the operands onto the shared unit's inputs.
- Waits SETTLE_CYCLES for the combinational path to settle, captures result and exception, and returns them to the granted requester.
- Keeps operation and exception statistics counters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SETTLE_CYCLES, 2, cycles the unit inputs are held stable before result capture (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-port request valid.
- req_ready  out  NUM_REQ  per-port accept; at most one bit high.
- req_a  in  32*NUM_REQ  operand A, port i at [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing.
- req_op  in  NUM_REQ  0 = add, 1 = subtract (A-B).
- resp_valid  out  NUM_REQ  per-port result valid; at most one bit high.
- resp_ready  in  NUM_REQ  per-port result accept.
- resp_res  out  32  result, shared by all ports.
- resp_exception  out  1  exception flag, shared by all ports.
- fpu_a  out  32  operand A to the shared unit (registered).
- fpu_b  out  32  operand B to the shared unit (registered).
- fpu_op  out  1  add_sub_signal to the shared unit (registered).
- fpu_res  in  32  result from the shared unit.
- fpu_exception  in  1  exception from the shared unit.
- busy  out  1  high whenever the state is not IDLE.
- ops_count  out  16  completed operations, saturating.
- exc_count  out  16  completed operations with exception=1, saturating.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, rr_ptr=0, settle counter=0.
  - All outputs 0: fpu_a/b/op, resp_res, resp_exception, resp_valid, ops_count, exc_count.
  - An in-flight operation is discarded with no response. Reset has priority over every other event.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally. req_ready is 0 in all other states and for all other ports.
  - On the accept edge: fpu_a <= A, fpu_b <= B, fpu_op <= op, gnt_id <= winner, cnt <= SETTLE_CYCLES, state -> EXEC.
  - No req_valid: stay in IDLE; fpu_* hold their previous values.
- EXEC:
  - cnt decrements each cycle.
  - On the edge where cnt==1: resp_res <= fpu_res, resp_exception <= fpu_exception, state -> RESP.
  - fpu_* are stable for exactly SETTLE_CYCLES cycles before capture.
- RESP:
  - resp_valid[gnt_id]=1; resp_res and resp_exception are held stable.
  - On resp_ready[gnt_id]=1: state -> IDLE, rr_ptr <= (gnt_id+1) mod NUM_REQ, ops_count += 1, exc_count += resp_exception. Both counters saturate at 0xFFFF.
  - resp_ready on non-granted ports is ignored.
- Latency:
  - Accept edge to resp_valid high = SETTLE_CYCLES+1 cycles.
  - Minimum issue interval = SETTLE_CYCLES+2 cycles (RESP with resp_ready already high, then one IDLE cycle).
- Request rules:
  - Requests are not queued. A request dropped before its grant is lost silently.
  - Operands must be valid only in the accept cycle.
- Fairness: a port that was just served has the lowest priority at the next arbitration; every persistent requester is served within NUM_REQ grants.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by rr_ptr.
- Result tagging: resp_res and resp_exception are meaningful only when some resp_valid bit is high; they hold their last value otherwise.

Test Plan:
- Single add: port 0 sends A=0x420151EC, B=0x4242147B, op=0, SETTLE=2 -> fpu_a/fpu_b change 1 cycle after accept; resp_valid[0] rises 3 cycles after accept with resp_res=0x42A1B333, resp_exception=0; ops_count=1.
- Subtract on port 2: A=0x40A00000, B=0x40C00000, op=1 -> resp_valid[2] with resp_res=0xBF800000; no other resp_valid bit ever high.
- All 4 ports request continuously from reset -> grants in order 0,1,2,3,0; each accept spaced exactly 4 cycles when resp_ready is tied high.
- Exception: A=0x7F800000, B=0x3EC7AE14, op=0 -> resp_res=0x7F800000, resp_exception=1, exc_count increments by 1.
- Backpressure: hold resp_ready[1]=0 for 10 cycles in RESP -> resp_valid[1] and resp_res are stable throughout; req_ready stays all-zero; the op completes on the first cycle resp_ready[1]=1.
- Reset mid-EXEC: drive reset=0 one cycle after accept -> next edge gives all outputs 0 and state IDLE; no resp_valid for the aborted op; after release, port 0 is granted first.
